// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, 2-flop column synchroniser,
// frame-level debounce FSM and registered BCD / press-level outputs.
module keypad_scanner #(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] data,
  output logic       is_pressed,
  output logic       is_star_pressed,
  output logic       is_hash_pressed
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // True when exactly one bit of the frame key map is set.
  function automatic logic is_single(input logic [11:0] m);
    return (m != 12'd0) && ((m & (m - 12'd1)) == 12'd0);
  endfunction

  // Position of the highest set key bit (only meaningful for a single key).
  function automatic logic [3:0] key_index(input logic [11:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Key map position (row*3+col) to 8421 BCD; '0' sits at r3/c1.
  function automatic logic [3:0] key_bcd(input logic [3:0] k);
    logic [3:0] b;
    case (k)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: b = k + 4'd1;
      default: b = 4'd0;
    endcase
    return b;
  endfunction

  logic [2:0]       col_s1_q, col_s2_q;
  logic             en_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [8:0]       map_q;
  logic [11:0]      frame_map_s;
  logic             scan_act_s, frame_end_s, single_s;
  logic [3:0]       key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             confirm_s, release_s;
  logic [3:0]       data_q, data_d;
  logic             pressed_q, pressed_d, star_q, star_d, hash_q, hash_d;
  logic             conf_q, conf_d;

  assign scan_act_s  = enable & en_q;
  assign frame_end_s = scan_act_s && (row_q == 2'd3) && (div_q == DIV_LAST);
  assign frame_map_s = {~col_s2_q, map_q};
  assign single_s    = is_single(frame_map_s);
  assign key_s       = key_index(frame_map_s);

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1_q <= 3'b111;
      col_s2_q <= 3'b111;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // Next divider/row; a cycle with en_q low re-arms r0 with the divider at 0.
  always_comb begin
    div_d   = div_q;
    row_d   = row_q;
    row_n_d = row_n_q;
    if (!enable) begin
      div_d   = '0;
      row_d   = 2'd0;
      row_n_d = 4'b1111;
    end else if (!en_q) begin
      div_d   = '0;
      row_d   = 2'd0;
      row_n_d = 4'b1110;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      row_d   = row_q + 2'd1;
      row_n_d = ~(4'b0001 << row_d);
    end else begin
      div_d   = div_q + DIV_ONE;
      row_n_d = row_n_q;
    end
  end

  // Scan counters and registered row drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b1;
      div_q   <= '0;
      row_q   <= 2'd0;
      row_n_q <= 4'b1110;
    end else begin
      en_q    <= enable;
      div_q   <= div_d;
      row_q   <= row_d;
      row_n_q <= row_n_d;
    end
  end

  // Capture rows 0..2 on their last cycle; row 3 is used live at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_q <= 9'd0;
    end else if (scan_act_s && (div_q == DIV_LAST)) begin
      case (row_q)
        2'd0:    map_q[2:0] <= ~col_s2_q;
        2'd1:    map_q[5:3] <= ~col_s2_q;
        2'd2:    map_q[8:6] <= ~col_s2_q;
        default: map_q      <= map_q;
      endcase
    end else begin
      map_q <= map_q;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Debounce FSM next state, evaluated only at frame end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    confirm_s = 1'b0;
    release_s = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (frame_end_s) begin
      case (state_q)
        ST_IDLE: begin
          if (single_s) begin
            cand_d = key_s;
            if (DEBOUNCE_FRAMES == 1) begin
              confirm_s = 1'b1;
              state_d   = ST_HELD;
              cnt_d     = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (single_s && (key_s == cand_q)) begin
            if (cnt_q == CNT_LAST) begin
              confirm_s = 1'b1;
              state_d   = ST_HELD;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (single_s) begin
            cand_d = key_s;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (single_s && (key_s == cand_q)) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            release_s = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output next values: data loads on confirm, the level follows one cycle later.
  always_comb begin
    data_d    = data_q;
    pressed_d = pressed_q;
    star_d    = star_q;
    hash_d    = hash_q;
    conf_d    = 1'b0;
    if (!enable) begin
      pressed_d = 1'b0;
      star_d    = 1'b0;
      hash_d    = 1'b0;
    end else begin
      if (confirm_s) begin
        conf_d = 1'b1;
        if ((key_s != KEY_STAR) && (key_s != KEY_HASH)) begin
          data_d = key_bcd(key_s);
        end else begin
          data_d = data_q;
        end
      end else begin
        conf_d = 1'b0;
      end
      if (conf_q) begin
        pressed_d = (cand_q != KEY_STAR) && (cand_q != KEY_HASH);
        star_d    = (cand_q == KEY_STAR);
        hash_d    = (cand_q == KEY_HASH);
      end else if (release_s) begin
        pressed_d = 1'b0;
        star_d    = 1'b0;
        hash_d    = 1'b0;
      end else begin
        pressed_d = pressed_q;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= 4'd0;
      pressed_q <= 1'b0;
      star_q    <= 1'b0;
      hash_q    <= 1'b0;
      conf_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      pressed_q <= pressed_d;
      star_q    <= star_d;
      hash_q    <= hash_d;
      conf_q    <= conf_d;
    end
  end

  assign row_n           = row_n_q;
  assign data            = data_q;
  assign is_pressed      = pressed_q;
  assign is_star_pressed = star_q;
  assign is_hash_pressed = hash_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives col_n,
// expected output changes are queued by the stimulus, a monitor pops and
// compares them (with their position relative to the frame end).
module tb_keypad_scanner;
  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] data;
  logic       is_pressed;
  logic       is_star_pressed;
  logic       is_hash_pressed;
  logic [11:0] keys;

  typedef struct {
    logic [3:0] data;
    logic [2:0] lv;     // {is_pressed, is_star_pressed, is_hash_pressed}
    int         phase;  // cycles after frame end, 0 = not frame aligned
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .col_n(col_n), .row_n(row_n),
    .data(data), .is_pressed(is_pressed), .is_star_pressed(is_star_pressed),
    .is_hash_pressed(is_hash_pressed)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (row_n[r] == 1'b0 && keys[r*3+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [3:0] d, input logic [2:0] lv, input int phase);
    exp_t e;
    e.data = d;
    e.lv = lv;
    e.phase = phase;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per observed output change.
  initial begin : monitor
    logic [6:0] prev_t;
    logic [6:0] cur_t;
    logic [3:0] prev_row;
    int cyc;
    int fe;
    exp_t e;
    cyc = 0;
    fe = -100;
    wait (mon_en);
    @(negedge clk);
    prev_t = {data, is_pressed, is_star_pressed, is_hash_pressed};
    prev_row = row_n;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_row == 4'b0111 && row_n != 4'b0111) fe = cyc - 1;
      prev_row = row_n;
      cur_t = {data, is_pressed, is_star_pressed, is_hash_pressed};
      if (cur_t !== prev_t) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected no change at %0t", cur_t, $time);
        end else begin
          e = exp_q.pop_front();
          check("event", {25'd0, cur_t}, {25'd0, e.data, e.lv});
          if (e.phase != 0) check("event_phase", cyc - fe, e.phase);
        end
      end
      prev_t = cur_t;
    end
  end

  initial begin : stim
    logic [3:0] exp_row;
    keys = 12'd0;
    enable = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {21'd0, row_n, data, is_pressed, is_star_pressed, is_hash_pressed},
          {21'd0, 4'b1110, 4'b0000, 3'b000});
    mon_en = 1'b1;

    // Reset mid-scan (currently in row 1), then row stepping from r0.
    cycles(21);
    reset = 1'b1;
    #1;
    check("reset_mid", {21'd0, row_n, data, is_pressed, is_star_pressed, is_hash_pressed},
          {21'd0, 4'b1110, 4'b0000, 3'b000});
    cycles(2);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (i / 4));
      check("row_step", {28'd0, row_n}, {28'd0, exp_row});
    end
    cycles(1);

    // Clean digit 5.
    expect_ev(4'd5, 3'b000, 1);
    expect_ev(4'd5, 3'b100, 2);
    expect_ev(4'd5, 3'b000, 1);
    keys = 12'd1 << 4;
    cycles(6 * FRAME);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("digit_done", exp_q.size(), 0);

    // Bounce on key 7: never three matching frames in a row.
    keys = 12'd1 << 6;
    cycles(2 * FRAME);
    keys = 12'd0;
    cycles(FRAME);
    keys = 12'd1 << 6;
    cycles(2 * FRAME);
    keys = 12'd0;
    cycles(4 * FRAME);
    check("bounce_done", exp_q.size(), 0);
    check("bounce_data", {28'd0, data}, 32'd5);

    // Star then hash: data stays 5.
    expect_ev(4'd5, 3'b010, 2);
    expect_ev(4'd5, 3'b000, 1);
    keys = 12'd1 << 9;
    cycles(4 * FRAME);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("star_done", exp_q.size(), 0);
    expect_ev(4'd5, 3'b001, 2);
    expect_ev(4'd5, 3'b000, 1);
    keys = 12'd1 << 11;
    cycles(4 * FRAME);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("hash_done", exp_q.size(), 0);

    // Multi-key: 1+2 never confirms; 8 confirms, adding 9 releases it.
    keys = 12'b0000_0000_0011;
    cycles(5 * FRAME);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("multi_none", exp_q.size(), 0);
    expect_ev(4'd8, 3'b000, 1);
    expect_ev(4'd8, 3'b100, 2);
    expect_ev(4'd8, 3'b000, 1);
    keys = 12'd1 << 7;
    cycles(4 * FRAME);
    check("multi_held8", {31'd0, is_pressed}, 32'd1);
    keys = keys | (12'd1 << 8);
    cycles(3 * FRAME);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("multi_done", exp_q.size(), 0);

    // Enable drop while 0 is held and confirmed, then re-enable.
    expect_ev(4'd0, 3'b000, 1);
    expect_ev(4'd0, 3'b100, 2);
    keys = 12'd1 << 10;
    cycles(5 * FRAME);
    check("zero_held", {28'd0, data}, 32'd0);
    expect_ev(4'd0, 3'b000, 0);
    enable = 1'b0;
    cycles(1);
    check("en_drop", {24'd0, row_n, is_pressed, is_star_pressed, is_hash_pressed, 1'b0},
          {24'd0, 4'b1111, 4'b0000});
    cycles(20);
    check("en_low_rows", {28'd0, row_n}, {28'd0, 4'b1111});
    check("en_low_data", {28'd0, data}, 32'd0);
    expect_ev(4'd0, 3'b100, 2);
    enable = 1'b1;
    cycles(5 * FRAME);
    expect_ev(4'd0, 3'b000, 1);
    keys = 12'd0;
    cycles(6 * FRAME);
    check("enable_done", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the safe's 4x3 matrix keypad, debounces it and encodes each key press for the comparator stage. Digit presses drive a held 8421 BCD code plus an `is_pressed` level. `*` and `#` drive their own levels. Every output comes from a register and changes synchronously, so the downstream length counter and register array see one clean edge per physical press.

## Interface
- `SCAN_DIV`, default 25000: clock cycles each row is driven; must be >= 4.
- `DEBOUNCE_FRAMES`, default 10: consecutive matching scan frames needed to confirm a press or a release; must be >= 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  safe on; low forces the block idle.
- `col_n`  in  3  keypad columns, active-low, externally pulled up, asynchronous to `clk`.
- `row_n`  out  4  keypad row drive, active-low, at most one row low.
- `data`  out  4  BCD of the last confirmed digit.
- `is_pressed`  out  1  high while a confirmed digit key is held.
- `is_star_pressed`  out  1  high while a confirmed `*` is held.
- `is_hash_pressed`  out  1  high while a confirmed `#` is held.

## Operation
- Key map, row/col: r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = `*`,0,`#`.
- Synchronisation: `col_n` passes through a 2-flop synchroniser before any use.
- Scan: a divider counts 0..SCAN_DIV-1 per row. Rows advance r0→r1→r2→r3→r0. A frame is 4*SCAN_DIV cycles.
- Sampling: synchronised columns are sampled on the last cycle of each row period. The samples build a 12-bit key map for the frame.
- Frame classification, at the last cycle of r3 (the "frame end"):
  - NONE: zero keys set.
  - SINGLE(k): exactly one key set.
  - MULTI: two or more keys set.
- FSM states, evaluated only at frame end:
  - IDLE: SINGLE(k) → cand=k, cnt=1, go DEBOUNCE. If DEBOUNCE_FRAMES=1, confirm immediately instead. NONE or MULTI → stay.
  - DEBOUNCE: SINGLE(cand) → cnt++. When cnt reaches DEBOUNCE_FRAMES → confirm, go HELD, cnt=0. SINGLE(other) → cand=other, cnt=1. NONE or MULTI → IDLE, cnt=0.
  - HELD: SINGLE(cand) → cnt=0. Anything else → cnt++. When cnt reaches DEBOUNCE_FRAMES → release, go IDLE.
- Confirm, digit: `data` loads the BCD of cand, then `is_pressed` rises.
- Confirm, `*` or `#`: `data` is unchanged and the matching level rises.
- Release: the active level falls. `data` keeps the last digit.
- At most one of the three press levels is high at any time.
- `enable` low: FSM forced to IDLE, counters cleared, all press levels 0, `row_n`=4'b1111, `data` held. Scanning restarts at r0 with the divider at 0 on the cycle after `enable` returns high.

## Timing
- Reset values: `row_n`=4'b1110, `data`=4'b0000, all press levels 0, state IDLE, divider 0, cnt 0. The synchroniser flops reset to 1 (no key).
- Confirm at frame-end cycle T: `data` is valid at T+1 and the press level rises at T+2. This gives one cycle of data setup before the edge.
- Release at frame-end cycle T: the press level falls at T+1.
- Minimum press-to-edge latency is DEBOUNCE_FRAMES frames plus 2 cycles. A column change reaches the sampler 2 cycles late, which is why SCAN_DIV >= 4.
- Reset mid-operation behaves exactly like power-up. No partial press or release edge is emitted after reset deasserts.
- Simultaneous `enable` falling and a confirm at the same frame end: `enable` wins and no level rises.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3, so a frame is 16 cycles.
- Reset: assert `reset` mid-scan → `row_n`=1110, `data`=0000, all levels 0 immediately. After release, `row_n` steps 1110→1101→1011→0111, 4 cycles each.
- Clean digit: hold key 5 (r1,c1) for 6 frames → `data`=0101 one cycle after the 3rd matching frame end, `is_pressed` high the next cycle. It falls one cycle after the 3rd empty frame following release.
- Bounce: key 7 for 2 frames, off 1 frame, on 2 frames, then released → no level ever rises and `data` is unchanged.
- Star after digit: after key 5, hold `*` for 4 frames → `is_star_pressed` pulses high and `data` stays 0101. Then hold `#` → only `is_hash_pressed` rises.
- Multi-key: press 1 and 2 together for 5 frames → nothing asserts. Hold 8 until confirmed, then add 9 for 3 frames → `is_pressed` falls one cycle after the 3rd MULTI frame end.
- Enable drop: drop `enable` while 0 is held and confirmed → `is_pressed`=0 and `row_n`=1111 next cycle, with `data` held at 0000. Re-enable while still holding 0 → a new rising edge after 3 frames.
